// File: rtl/alu_seq_pkg.sv
// Shared op codes, sequencer states and the ALU control encodings used by the
// multi-cycle multiply/shift sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SHL = 2'b01,
        OP_SHR = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL_ADD   = 3'd1,
        ST_MUL_SHIFT = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Function codes are {M, S3..S0} for the 74181 path; the shifter only
    // looks at bit 0 to choose direction.
    localparam logic [4:0] ALU_F_A           = 5'b11111;
    localparam logic [4:0] ALU_F_ADD         = 5'b01001;
    localparam logic [4:0] ALU_F_SHIFT_LEFT  = 5'b00000;
    localparam logic [4:0] ALU_F_SHIFT_RIGHT = 5'b00001;

    localparam logic ALU_FSEL_74181 = 1'b0;
    localparam logic ALU_FSEL_SHIFT = 1'b1;

    localparam logic ALU_CSEL_UCIN  = 1'b0;
    localparam logic ALU_CSEL_FCIN  = 1'b1;

endpackage

// File: rtl/alu_seq_if.sv
// Control/data bus between the sequencer (master) and the 16-bit ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_f;
    logic             alu_fsel;
    logic             alu_csel;
    logic             alu_ucin;
    logic             alu_fcin;
    logic             alu_yoe;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             alu_zout;

    modport master (
        output alu_a, alu_b, alu_f, alu_fsel, alu_csel, alu_ucin, alu_fcin, alu_yoe,
        input  alu_y, alu_cout, alu_zout
    );

    modport slave (
        input  alu_a, alu_b, alu_f, alu_fsel, alu_csel, alu_ucin, alu_fcin, alu_yoe,
        output alu_y, alu_cout, alu_zout
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle sequencer that builds 16x16 (low half) multiply and N-bit shifts
// out of repeated single-step passes through the shared ALU.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cflag,
    output logic             zflag,
    output logic             err,
    alu_seq_if.master        alu
);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     val_q, val_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 cacc_q, cacc_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 cflag_q, cflag_d;
    logic                 zflag_q, zflag_d;
    logic                 err_q, err_d;

    logic                 fin;
    logic [WIDTH-1:0]     fin_res;
    logic                 fin_c;
    logic                 fin_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            val_q    <= '0;
            cnt_q    <= '0;
            cacc_q   <= 1'b0;
            result_q <= '0;
            cflag_q  <= 1'b0;
            zflag_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            cacc_q   <= cacc_d;
            result_q <= result_d;
            cflag_q  <= cflag_d;
            zflag_q  <= zflag_d;
            err_q    <= err_d;
        end
    end

    // Result and flags are captured on the edge that enters DONE, so they are
    // valid during DONE and hold afterwards without depending on acc/val.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        cacc_d   = cacc_q;
        result_d = result_q;
        cflag_d  = cflag_q;
        zflag_d  = zflag_q;
        err_d    = err_q;
        fin      = 1'b0;
        fin_res  = '0;
        fin_c    = 1'b0;
        fin_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op_e'(op);
                    case (op_e'(op))
                        OP_MUL: begin
                            mcand_d  = opa;
                            mplier_d = opb;
                            acc_d    = '0;
                            cacc_d   = 1'b0;
                            if (opb == '0) begin
                                state_d = ST_DONE;
                                fin     = 1'b1;
                            end else if (opb[0]) begin
                                state_d = ST_MUL_ADD;
                            end else begin
                                state_d = ST_MUL_SHIFT;
                            end
                        end
                        OP_SHL, OP_SHR: begin
                            val_d = opa;
                            cnt_d = opb[SHAMT_W-1:0];
                            if (opb[SHAMT_W-1:0] == '0) begin
                                state_d = ST_DONE;
                                fin     = 1'b1;
                                fin_res = opa;
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL_ADD: begin
                acc_d   = alu.alu_y;
                cacc_d  = cacc_q | alu.alu_cout;
                state_d = ST_MUL_SHIFT;
            end
            ST_MUL_SHIFT: begin
                mcand_d  = alu.alu_y;
                mplier_d = mplier_q >> 1;
                if (mplier_d == '0) begin
                    state_d = ST_DONE;
                    fin     = 1'b1;
                    fin_res = acc_q;
                    fin_c   = cacc_q;
                end else if (mplier_d[0]) begin
                    state_d = ST_MUL_ADD;
                end else begin
                    state_d = ST_MUL_SHIFT;
                end
            end
            ST_SHIFT: begin
                val_d = alu.alu_y;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                    fin     = 1'b1;
                    fin_res = alu.alu_y;
                    fin_c   = (op_q == OP_SHL) ? val_q[WIDTH-1] : val_q[0];
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            result_d = fin_res;
            cflag_d  = fin_c;
            zflag_d  = (fin_res == '0);
            err_d    = fin_err;
        end
    end

    always_comb begin
        alu.alu_a    = '0;
        alu.alu_b    = '0;
        alu.alu_f    = ALU_F_A;
        alu.alu_fsel = ALU_FSEL_74181;
        alu.alu_csel = ALU_CSEL_UCIN;
        alu.alu_ucin = 1'b0;
        alu.alu_fcin = 1'b0;
        alu.alu_yoe  = 1'b0;
        case (state_q)
            ST_MUL_ADD: begin
                alu.alu_a   = acc_q;
                alu.alu_b   = mcand_q;
                alu.alu_f   = ALU_F_ADD;
                alu.alu_yoe = 1'b1;
            end
            ST_MUL_SHIFT: begin
                alu.alu_a    = mcand_q;
                alu.alu_fsel = ALU_FSEL_SHIFT;
                alu.alu_f    = ALU_F_SHIFT_LEFT;
                alu.alu_yoe  = 1'b1;
            end
            ST_SHIFT: begin
                alu.alu_a    = val_q;
                alu.alu_fsel = ALU_FSEL_SHIFT;
                alu.alu_f    = (op_q == OP_SHR) ? ALU_F_SHIFT_RIGHT : ALU_F_SHIFT_LEFT;
                alu.alu_yoe  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cflag  = cflag_q;
    assign zflag  = zflag_q;
    assign err    = err_q;

    // Whenever the ALU result is consumed, its zero output must agree with it.
    a_alu_zout: assert property (@(posedge clock) disable iff (!reset_n)
                                 alu.alu_yoe |-> (alu.alu_zout == (alu.alu_y == '0)));

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with a behavioural 16-bit ALU on the bus.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa, opb;
    logic        busy, done, cflag, zflag, err;
    logic [15:0] result;

    int passed = 0;
    int total  = 0;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .start   (start),
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cflag   (cflag),
        .zflag   (zflag),
        .err     (err),
        .alu     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: single-bit shifter plus 74181 add / pass-A.
    always_comb begin
        bus.alu_y    = bus.alu_a;
        bus.alu_cout = 1'b0;
        if (bus.alu_fsel == ALU_FSEL_SHIFT) begin
            if (bus.alu_f == ALU_F_SHIFT_RIGHT) bus.alu_y = {1'b0, bus.alu_a[15:1]};
            else                                bus.alu_y = {bus.alu_a[14:0], 1'b0};
        end else if (bus.alu_f == ALU_F_ADD) begin
            {bus.alu_cout, bus.alu_y} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, bus.alu_ucin};
        end
        bus.alu_zout = (bus.alu_y == 16'h0000);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request, then waits (bounded) for done; on return we sit in
    // the DONE cycle. Optionally pulses a rogue start in cycle 'glitch'.
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input int glitch, output int cyc, output int nalu,
                         output logic [31:0] fseq, output bit yoe_seen);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; op = 2'b10; opa = 16'hFFFF; opb = 16'hFFFF;
        cyc = 1; nalu = 0; fseq = '0; yoe_seen = 1'b0;
        while (done !== 1'b1 && cyc < 200) begin
            if (bus.alu_yoe === 1'b1) begin
                yoe_seen = 1'b1;
                nalu++;
                fseq = {fseq[30:0], bus.alu_fsel};
            end
            start = (cyc == glitch);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++; if ({cflag, zflag, err} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {cflag, zflag, err}); else passed++;
        total++; if (result !== 16'h0000) $display("FAIL rst_result: got %h want 0000", result); else passed++;
        total++; if (bus.alu_yoe !== 1'b0) $display("FAIL rst_yoe: got %b want 0", bus.alu_yoe); else passed++;
        total++; if (bus.alu_f !== ALU_F_A) $display("FAIL rst_alu_f: got %b want %b", bus.alu_f, ALU_F_A); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int cyc, nalu; logic [31:0] fseq; bit ys;
        do_op(2'b00, 16'h0003, 16'h0005, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 6) $display("FAIL mul35_latency: got %0d want 6", cyc); else passed++;
        total++; if (nalu !== 5) $display("FAIL mul35_alu_cycles: got %0d want 5", nalu); else passed++;
        total++; if (fseq !== 32'h0000000D) $display("FAIL mul35_fsel_seq: got %h want 0000000d", fseq); else passed++;
        total++; if (result !== 16'h000F) $display("FAIL mul35_result: got %h want 000f", result); else passed++;
        total++; if ({cflag, zflag, err} !== 3'b000) $display("FAIL mul35_flags: got %b want 000", {cflag, zflag, err}); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL mul35_busy_done: got %b want 1", busy); else passed++;
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) $display("FAIL mul35_idle: got %b want 00", {busy, done}); else passed++;
        total++; if (result !== 16'h000F) $display("FAIL mul35_hold: got %h want 000f", result); else passed++;

        do_op(2'b00, 16'hC000, 16'h0003, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 5) $display("FAIL mulc_latency: got %0d want 5", cyc); else passed++;
        total++; if (result !== 16'h4000) $display("FAIL mulc_result: got %h want 4000", result); else passed++;
        total++; if ({cflag, zflag} !== 2'b10) $display("FAIL mulc_flags: got %b want 10", {cflag, zflag}); else passed++;

        do_op(2'b00, 16'h1234, 16'h0000, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 1) $display("FAIL mul0_latency: got %0d want 1", cyc); else passed++;
        total++; if (result !== 16'h0000) $display("FAIL mul0_result: got %h want 0000", result); else passed++;
        total++; if ({cflag, zflag} !== 2'b01) $display("FAIL mul0_flags: got %b want 01", {cflag, zflag}); else passed++;
        total++; if (ys !== 1'b0) $display("FAIL mul0_yoe: got %b want 0", ys); else passed++;
    endtask

    task automatic test_shift();
        int cyc, nalu; logic [31:0] fseq; bit ys;
        do_op(2'b01, 16'hF031, 16'h0004, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 5) $display("FAIL shl4_latency: got %0d want 5", cyc); else passed++;
        total++; if (result !== 16'h0310) $display("FAIL shl4_result: got %h want 0310", result); else passed++;
        total++; if ({cflag, zflag} !== 2'b10) $display("FAIL shl4_flags: got %b want 10", {cflag, zflag}); else passed++;

        do_op(2'b10, 16'hF031, 16'h0001, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 2) $display("FAIL shr1_latency: got %0d want 2", cyc); else passed++;
        total++; if (result !== 16'h7818) $display("FAIL shr1_result: got %h want 7818", result); else passed++;
        total++; if (cflag !== 1'b1) $display("FAIL shr1_cflag: got %b want 1", cflag); else passed++;

        // Only opb[3:0] counts: 0x13 shifts by 3.
        do_op(2'b01, 16'h00FF, 16'h0013, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 4) $display("FAIL shl3_latency: got %0d want 4", cyc); else passed++;
        total++; if (result !== 16'h07F8) $display("FAIL shl3_result: got %h want 07f8", result); else passed++;
        total++; if (cflag !== 1'b0) $display("FAIL shl3_cflag: got %b want 0", cflag); else passed++;
    endtask

    task automatic test_edge_ops();
        int cyc, nalu; logic [31:0] fseq; bit ys;
        do_op(2'b01, 16'hA5A5, 16'h0000, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 1) $display("FAIL shl0_latency: got %0d want 1", cyc); else passed++;
        total++; if (result !== 16'hA5A5) $display("FAIL shl0_result: got %h want a5a5", result); else passed++;
        total++; if ({cflag, zflag, ys} !== 3'b000) $display("FAIL shl0_flags_yoe: got %b want 000", {cflag, zflag, ys}); else passed++;

        do_op(2'b11, 16'h5555, 16'h0003, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 1) $display("FAIL ill_latency: got %0d want 1", cyc); else passed++;
        total++; if (err !== 1'b1) $display("FAIL ill_err: got %b want 1", err); else passed++;
        total++; if (result !== 16'h0000) $display("FAIL ill_result: got %h want 0000", result); else passed++;
        total++; if (cflag !== 1'b0) $display("FAIL ill_cflag: got %b want 0", cflag); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc, nalu; logic [31:0] fseq; bit ys;
        do_op(2'b00, 16'h0003, 16'h0005, 2, cyc, nalu, fseq, ys);
        total++; if (cyc !== 6) $display("FAIL b2b_latency: got %0d want 6", cyc); else passed++;
        total++; if (result !== 16'h000F) $display("FAIL b2b_result: got %h want 000f", result); else passed++;
        total++; if (err !== 1'b0) $display("FAIL b2b_err_clear: got %b want 0", err); else passed++;
        // A start presented during DONE must not be accepted.
        start = 1'b1; op = 2'b01; opa = 16'h0001; opb = 16'h0002;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL b2b_done_start: got busy %b want 0", busy); else passed++;
        @(negedge clk);
        total++; if (result !== 16'h000F) $display("FAIL b2b_done_hold: got %h want 000f", result); else passed++;
    endtask

    task automatic test_reset_mid();
        int cyc, nalu; logic [31:0] fseq; bit ys; bit done_seen;
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 16'h0003; opb = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, cflag, zflag, err} !== 5'b00000) $display("FAIL rstmid_ctrl: got %b want 00000", {busy, done, cflag, zflag, err}); else passed++;
        total++; if (result !== 16'h0000) $display("FAIL rstmid_result: got %h want 0000", result); else passed++;
        total++; if (bus.alu_yoe !== 1'b0) $display("FAIL rstmid_yoe: got %b want 0", bus.alu_yoe); else passed++;
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        total++; if (done_seen !== 1'b0) $display("FAIL rstmid_no_done: got %b want 0", done_seen); else passed++;

        do_op(2'b10, 16'h8000, 16'h000F, 0, cyc, nalu, fseq, ys);
        total++; if (cyc !== 16) $display("FAIL post_rst_latency: got %0d want 16", cyc); else passed++;
        total++; if (result !== 16'h0001) $display("FAIL post_rst_result: got %h want 0001", result); else passed++;
        total++; if ({cflag, zflag} !== 2'b00) $display("FAIL post_rst_flags: got %b want 00", {cflag, zflag}); else passed++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_shift();
        test_edge_ops();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
